// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot opcode type, opcode bit indices and the
// arbiter response-slot state encoding.
// Imported by alu and alu_arbiter.
package alu_pkg;

   typedef logic [11:0] alu_op_t;

   localparam int ALU_OP_ADD  = 0;
   localparam int ALU_OP_SUB  = 1;
   localparam int ALU_OP_SLT  = 2;
   localparam int ALU_OP_SLTU = 3;
   localparam int ALU_OP_AND  = 4;
   localparam int ALU_OP_NOR  = 5;
   localparam int ALU_OP_OR   = 6;
   localparam int ALU_OP_XOR  = 7;
   localparam int ALU_OP_SLL  = 8;
   localparam int ALU_OP_SRL  = 9;
   localparam int ALU_OP_SRA  = 10;
   localparam int ALU_OP_LUI  = 11;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by a one-hot opcode; result is the OR of
// every selected sub-result, so a zero opcode yields 0.
// Ports: alu_op_i (one-hot op), alu_src1_i/alu_src2_i (operands), alu_result_o.
module alu
   import alu_pkg::*;
(
   input  alu_op_t     alu_op_i,
   input  logic [31:0] alu_src1_i,
   input  logic [31:0] alu_src2_i,
   output logic [31:0] alu_result_o
);

   logic [4:0]  shamt;
   logic [31:0] add_res, sub_res, slt_res, sltu_res;
   logic [31:0] and_res, nor_res, or_res, xor_res;
   logic [31:0] sll_res, srl_res, sra_res, lui_res;

   assign shamt    = alu_src2_i[4:0];
   assign add_res  = alu_src1_i + alu_src2_i;
   assign sub_res  = alu_src1_i - alu_src2_i;
   assign slt_res  = {31'd0, ($signed(alu_src1_i) < $signed(alu_src2_i))};
   assign sltu_res = {31'd0, (alu_src1_i < alu_src2_i)};
   assign and_res  = alu_src1_i & alu_src2_i;
   assign nor_res  = ~(alu_src1_i | alu_src2_i);
   assign or_res   = alu_src1_i | alu_src2_i;
   assign xor_res  = alu_src1_i ^ alu_src2_i;
   assign sll_res  = alu_src1_i << shamt;
   assign srl_res  = alu_src1_i >> shamt;
   assign sra_res  = $signed(alu_src1_i) >>> shamt;
   assign lui_res  = {alu_src2_i[15:0], 16'd0};

   // Masking each sub-result with its op bit and OR-ing them gives the
   // defined behaviour for non-one-hot opcodes without extra decode.
   assign alu_result_o = ({32{alu_op_i[ALU_OP_ADD]}}  & add_res)
                       | ({32{alu_op_i[ALU_OP_SUB]}}  & sub_res)
                       | ({32{alu_op_i[ALU_OP_SLT]}}  & slt_res)
                       | ({32{alu_op_i[ALU_OP_SLTU]}} & sltu_res)
                       | ({32{alu_op_i[ALU_OP_AND]}}  & and_res)
                       | ({32{alu_op_i[ALU_OP_NOR]}}  & nor_res)
                       | ({32{alu_op_i[ALU_OP_OR]}}   & or_res)
                       | ({32{alu_op_i[ALU_OP_XOR]}}  & xor_res)
                       | ({32{alu_op_i[ALU_OP_SLL]}}  & sll_res)
                       | ({32{alu_op_i[ALU_OP_SRL]}}  & srl_res)
                       | ({32{alu_op_i[ALU_OP_SRA]}}  & sra_res)
                       | ({32{alu_op_i[ALU_OP_LUI]}}  & lui_res);

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; results return through a single registered
// response slot (1-cycle latency, full throughput when drained every cycle).
// Ports: clk, reset (sync, active-high), req0_*/req1_* valid/ready/op/src1/
// src2/tag, rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_id.
// Build option: ALU_ARB_RR_EN selects round-robin, otherwise req0 has priority.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  alu_op_t          req0_op,
   input  logic [31:0]      req0_src1,
   input  logic [31:0]      req0_src2,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  alu_op_t          req1_op,
   input  logic [31:0]      req1_src1,
   input  logic [31:0]      req1_src2,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_id
);

   arb_state_t       state_q, state_d;
   logic [31:0]      result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             id_q, id_d;

   logic             grant0, grant1, can_accept, accept;
   alu_op_t          alu_op;
   logic [31:0]      alu_src1, alu_src2, alu_result;

`ifdef ALU_ARB_RR_EN
   // Names the requester preferred on the next tie.
   logic ptr_q, ptr_d;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
`ifdef ALU_ARB_RR_EN
      if (req0_valid && req1_valid) begin
         grant0 = ~ptr_q;
         grant1 = ptr_q;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
   end

   assign can_accept = (state_q == ARB_EMPTY) | ((state_q == ARB_FULL) & rsp_ready);
   assign req0_ready = grant0 & can_accept & ~reset;
   assign req1_ready = grant1 & can_accept & ~reset;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   // Operand mux keyed on grant1; with no grant the ALU output is unused.
   assign alu_op   = grant1 ? req1_op   : req0_op;
   assign alu_src1 = grant1 ? req1_src1 : req0_src1;
   assign alu_src2 = grant1 ? req1_src2 : req0_src2;

   alu u_alu (
      .alu_op_i     (alu_op),
      .alu_src1_i   (alu_src1),
      .alu_src2_i   (alu_src2),
      .alu_result_o (alu_result)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      tag_d    = tag_q;
      id_d     = id_q;
      if (accept) begin
         // Covers both a load into EMPTY and drain-plus-refill when FULL.
         state_d  = ARB_FULL;
         result_d = alu_result;
         tag_d    = grant1 ? req1_tag : req0_tag;
         id_d     = grant1;
      end else if ((state_q == ARB_FULL) && rsp_ready) begin
         state_d = ARB_EMPTY;
      end
   end

`ifdef ALU_ARB_RR_EN
   // After an accept from requester N the other one is preferred.
   assign ptr_d = accept ? grant0 : ptr_q;

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_EMPTY;
         result_q <= '0;
         tag_q    <= '0;
         id_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         tag_q    <= tag_d;
         id_q     <= id_d;
      end
   end

   assign rsp_valid  = (state_q == ARB_FULL);
   assign rsp_result = result_q;
   assign rsp_tag    = tag_q;
   assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [11:0]      req0_op, req1_op;
   logic [31:0]      req0_src1, req0_src2, req1_src1, req1_src2;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]      result;
      logic [TAG_W-1:0] tag;
      logic             id;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [11:0] op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] exp;
   } vec_t;

   bit ptr_m = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_id(rsp_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock cycle: inputs are already set (1 time unit after posedge).
   // At the falling edge, check handshakes and the response slot against
   // the scoreboard, then push what should be accepted this cycle.
   task automatic step(input string name, input logic [31:0] res0, input logic [31:0] res1);
      bit   can, g0, g1, e0, e1;
      exp_t e;
      @(negedge clk);
      if (reset) begin
         chk({name, ".r0_rst"}, {31'd0, req0_ready}, 32'd0);
         chk({name, ".r1_rst"}, {31'd0, req1_ready}, 32'd0);
         sb.delete();
         ptr_m = 1'b0;
      end else begin
         can = (sb.size() == 0) || rsp_ready;
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            g0 = !ptr_m; g1 = ptr_m;
`else
            g0 = 1'b1; g1 = 1'b0;
`endif
         end else begin
            g0 = req0_valid; g1 = req1_valid;
         end
         e0 = g0 && can;
         e1 = g1 && can;
         chk({name, ".r0"}, {31'd0, req0_ready}, {31'd0, e0});
         chk({name, ".r1"}, {31'd0, req1_ready}, {31'd0, e1});
         chk({name, ".vld"}, {31'd0, rsp_valid}, {31'd0, (sb.size() != 0)});
         if (sb.size() != 0 && rsp_valid) begin
            chk({name, ".res"}, rsp_result, sb[0].result);
            chk({name, ".tag"}, {28'd0, rsp_tag}, {28'd0, sb[0].tag});
            chk({name, ".id"}, {31'd0, rsp_id}, {31'd0, sb[0].id});
         end
         if (sb.size() != 0 && rsp_ready) void'(sb.pop_front());
         if (e0) begin
            e.result = res0; e.tag = req0_tag; e.id = 1'b0; sb.push_back(e);
            ptr_m = 1'b1;
         end else if (e1) begin
            e.result = res1; e.tag = req1_tag; e.id = 1'b1; sb.push_back(e);
            ptr_m = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string name);
      @(negedge clk);
      chk({name, ".vld0"}, {31'd0, rsp_valid}, 32'd0);
      chk({name, ".res0"}, rsp_result, 32'd0);
      chk({name, ".tag0"}, {28'd0, rsp_tag}, 32'd0);
      chk({name, ".id0"}, {31'd0, rsp_id}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{"add",     12'h001, 32'd5,        32'd7,        32'd12};
      vecs[1]  = '{"sub",     12'h002, 32'd3,        32'd5,        32'hFFFFFFFE};
      vecs[2]  = '{"slt",     12'h004, 32'h80000000, 32'd1,        32'd1};
      vecs[3]  = '{"sltu",    12'h008, 32'h80000000, 32'd1,        32'd0};
      vecs[4]  = '{"sra",     12'h400, 32'h80000000, 32'h21,       32'hC0000000};
      vecs[5]  = '{"and",     12'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
      vecs[6]  = '{"nor",     12'h020, 32'd0,        32'd0,        32'hFFFFFFFF};
      vecs[7]  = '{"or",      12'h040, 32'h0F0,      32'h00F,      32'hFF};
      vecs[8]  = '{"xor",     12'h080, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
      vecs[9]  = '{"sll31",   12'h100, 32'd1,        32'd31,       32'h80000000};
      vecs[10] = '{"sll32",   12'h100, 32'd1,        32'd32,       32'd1};
      vecs[11] = '{"srl",     12'h200, 32'h80000000, 32'd4,        32'h08000000};
      vecs[12] = '{"addwrap", 12'h001, 32'hFFFFFFFF, 32'd2,        32'd1};
      vecs[13] = '{"op0",     12'h000, 32'h1234,     32'h5678,     32'd0};
      vecs[14] = '{"addxor",  12'h081, 32'd6,        32'd3,        32'hD};

      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_tag = '0;
      req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'd1; req1_src2 = 32'd1; req1_tag = '0;
      @(posedge clk);
      #1;
      step("rst", 32'd0, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      chk_zero("after_rst");

      // Single-requester table, response drained every cycle.
      rsp_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         req0_valid = 1'b1;
         req0_op    = vecs[i].op;
         req0_src1  = vecs[i].src1;
         req0_src2  = vecs[i].src2;
         req0_tag   = 4'(i);
         step(vecs[i].name, vecs[i].exp, 32'd0);
      end
      req0_valid = 1'b0;
      step("drain_tbl", 32'd0, 32'd0);

      // Contention: both valid every cycle.
      for (int i = 0; i < 6; i++) begin
         req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'(i); req0_src2 = 32'd100; req0_tag = 4'(i);
         req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'(i); req1_src2 = 32'd200; req1_tag = 4'(i + 8);
         step("contend", 32'(i) + 32'd100, 32'(i) + 32'd200);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step("drain_cont", 32'd0, 32'd0);

      // Backpressure: slot holds 3-5, consumer stalls for 3 cycles.
      req0_valid = 1'b1; req0_op = 12'h002; req0_src1 = 32'd3; req0_src2 = 32'd5; req0_tag = 4'd5;
      step("bp_load", 32'hFFFFFFFE, 32'd0);
      rsp_ready = 1'b0;
      req0_op = 12'h001; req0_src1 = 32'd9; req0_src2 = 32'd9;
      req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'd10; req1_src2 = 32'd20; req1_tag = 4'd7;
      for (int i = 0; i < 3; i++) step("bp_stall", 32'd18, 32'd30);
      req0_valid = 1'b0;
      rsp_ready = 1'b1;
      step("bp_drain_acc", 32'd18, 32'd30);
      req1_valid = 1'b0;
      step("bp_drain", 32'd0, 32'd0);

      // Reset while the slot is full and stalled.
      req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_tag = 4'd9;
      step("mid_load", 32'd2, 32'd0);
      req0_valid = 1'b0; rsp_ready = 1'b0;
      step("mid_hold", 32'd0, 32'd0);
      reset = 1'b1;
      step("mid_rst", 32'd0, 32'd0);
      reset = 1'b0;
      chk_zero("mid_after");
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 12'h001; req0_src1 = 32'd40; req0_src2 = 32'd2; req0_tag = 4'd1;
      req1_valid = 1'b1; req1_op = 12'h001; req1_src1 = 32'd50; req1_src2 = 32'd3; req1_tag = 4'd2;
      step("post_rst", 32'd42, 32'd53);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step("post_drain", 32'd0, 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, the width of the requester transaction tag.
REQ-002 SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port reqN_valid (N=0,1), input, 1, requester N presents an operation.
REQ-005 SHALL have port reqN_ready (N=0,1), output, 1, requester N's operation is accepted this cycle.
REQ-006 SHALL have port reqN_op (N=0,1), input, 12, one-hot ALU op: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
REQ-007 SHALL have ports reqN_src1 and reqN_src2 (N=0,1), input, 32 each, operands.
REQ-008 SHALL have port reqN_tag (N=0,1), input, TAG_W, opaque tag returned with the result.
REQ-009 SHALL have port rsp_valid, output, 1, a result is held on the rsp_* outputs.
REQ-010 SHALL have port rsp_ready, input, 1, the consumer takes the result this cycle.
REQ-011 SHALL have ports rsp_result (output, 32), rsp_tag (output, TAG_W) and rsp_id (output, 1, index of the originating requester).

Function
REQ-012 SHALL share one combinational ALU instance between the two requesters and return results through one registered response slot.
REQ-013 SHALL use a two-state FSM: EMPTY (slot free) and FULL (slot holds an undelivered result).
REQ-014 SHALL define can_accept = (state==EMPTY) | (state==FULL & rsp_ready).
REQ-015 SHALL grant at most one requester per cycle; reqN_ready = grantN & can_accept, and grantN is 0 when reqN_valid is 0.
REQ-016 SHALL, on an accept (reqN_valid & reqN_ready), register the ALU result, reqN_tag and N into the slot; rsp_valid is 1 on the next cycle, giving a latency of exactly one cycle.
REQ-017 SHALL feed the granted requester's op and operands to the ALU; when there is no grant the ALU inputs are don't-care and no state changes.
REQ-018 SHALL handle a drain with no new accept as FULL -> EMPTY.
REQ-019 SHALL handle a drain with a simultaneous accept as staying FULL with the new result; there is no bubble, giving a sustained throughput of 1 per cycle.
REQ-020 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL produce, for a non-one-hot or zero op, the bitwise OR of the selected sub-results (zero op gives 0); no error is flagged.
REQ-022 SHALL compute shift amounts from src2[4:0] only; add and sub wrap modulo 2^32.
REQ-023 SHALL register rsp_result, rsp_tag, rsp_id and rsp_valid directly, with no combinational path from reqN_* to rsp_*.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set state EMPTY, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_id=0 and the priority pointer to requester 0.
REQ-025 SHALL drive reqN_ready=0 during any reset cycle and discard an in-flight result on a reset mid-operation.

Configuration
REQ-026 SHALL, with ALU_ARB_RR_EN defined, use round-robin arbitration: the pointer names the preferred requester, and after each accept from requester N it moves to 1-N; with only one valid requester, that requester is granted regardless of the pointer.
REQ-027 SHALL, with ALU_ARB_RR_EN undefined, use fixed priority: requester 0 always wins on a tie, and the pointer register is not instantiated.

Structure
REQ-028 SHALL take from a shared package alu_pkg: typedef alu_op_t (12-bit), localparams ALU_OP_ADD..ALU_OP_LUI (bit indices 0..11), and the FSM state enum arb_state_t {ARB_EMPTY, ARB_FULL}.
REQ-029 SHALL instantiate exactly one sub-module, the existing alu, with no ALU logic duplicated inside the arbiter.

Verification
REQ-030 SHALL cover a single request: req0 valid with op add(0x001), src1=5, src2=7, tag=3, rsp_ready=1 -> req0_ready=1 that cycle, and next cycle rsp_valid=1, result=12, tag=3, id=0.
REQ-031 SHALL cover contention: both valid every cycle with rsp_ready=1 and ALU_ARB_RR_EN defined -> ids alternate 0,1,0,1; with the macro undefined -> id always 0 and req1_ready never 1.
REQ-032 SHALL cover backpressure: slot FULL holding sub(0x002) 3-5 = 0xFFFFFFFE and rsp_ready=0 for 3 cycles -> rsp_* constant, both reqN_ready=0; when rsp_ready rises with req1 valid -> drain and accept in the same cycle.
REQ-033 SHALL cover signed compares: slt with src1=0x80000000, src2=1 -> result 1; sltu with the same operands -> 0; sra 0x80000000 by src2=0x21 -> 0xC0000000 (shift by 1).
REQ-034 SHALL cover reset mid-operation: reset asserted while FULL with rsp_ready=0 -> next cycle rsp_valid=0 and all rsp_* outputs 0; after reset release with both requesters valid -> first grant goes to req0.
